regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback (WB) and a long-latency unit (MDU: multiply/divide/load-miss return).
- Pipeline WB has fixed priority. MDU results are buffered in a small FIFO and drained when the port is idle.
- Provides pending-write hit flags to the hazard unit, and a stall request so buffered results cannot starve.

Parameters:
- FIFO_DEPTH, 2, MDU result buffer entries (power of 2, ≥2).
- MAX_WAIT, 4, consecutive cycles a non-empty FIFO may be blocked before stall_req asserts (≥1).

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- pipe_we  in  1  pipeline WB write enable.
- pipe_rd  in  5  pipeline WB destination register.
- pipe_wdata  in  32  pipeline WB data.
- mdu_valid  in  1  MDU result valid.
- mdu_rd  in  5  MDU destination register.
- mdu_wdata  in  32  MDU result data.
- mdu_ready  out  1  FIFO can accept; handshake = mdu_valid & mdu_ready.
- chk_rs1  in  5  hazard-unit source register 1.
- chk_rs2  in  5  hazard-unit source register 2.
- pend_hit1  out  1  a live FIFO entry targets chk_rs1 (chk_rs1≠0).
- pend_hit2  out  1  same for chk_rs2.
- stall_req  out  1  registered request to freeze pipeline WB.
- rf_RegWrite  out  1  register-file write enable (registered).
- rf_WriteReg  out  5  register-file write address (registered).
- rf_WriteData  out  32  register-file write data (registered).

Behaviour:
- Reset (reset_n=0, async): FIFO empty, all entry live bits 0, wait counter 0, FSM=IDLE. rf_RegWrite=0, rf_WriteReg=0, rf_WriteData=0, stall_req=0. Holds while low; a reset mid-queue discards all entries.
- Effective pipe write: pipe_we & (pipe_rd≠0). Writes to x0 are never issued.
- mdu_ready = (count < FIFO_DEPTH). It depends only on registered count; there is no pass-through when full.
- Push on handshake. If mdu_rd=0, the result is accepted but not queued (dropped).
- Entry fields: live, rd, data.
- Port select each cycle:
  - Effective pipe write → register pipe_rd/pipe_wdata into rf_* with rf_RegWrite=1 next cycle.
  - Else FIFO non-empty → pop head. rf_RegWrite = head.live; rd/data = head fields.
  - Else rf_RegWrite=0; rf_WriteReg/rf_WriteData hold their last values.
- Latency:
  - Pipe write appears on rf_* the cycle after pipe_we.
  - MDU handshake in cycle N → entry in FIFO at N+1 → earliest pop N+1 → rf_RegWrite high in N+2.
- WAW squash: an effective pipe write whose rd matches any live entry clears that entry's live bit in the same edge, because the pipe value is younger. A squashed entry is still popped in order, producing no write.
- Simultaneous push and pop in one cycle: both occur; count unchanged.
- pend_hit1/2 are combinational: OR over live entries of (rd==chk_rsX), gated by chk_rsX≠0. Squashed entries never hit. The entry being pushed this cycle does not hit.
- FSM (wait counter wcnt, 0..MAX_WAIT):
  - IDLE: FIFO empty, wcnt=0.
    - → WAIT when count becomes non-zero.
  - WAIT: each cycle the FIFO is non-empty and no pop occurs, wcnt+1. A pop resets wcnt=0.
    - → IDLE if FIFO becomes empty.
    - → FORCE when wcnt reaches MAX_WAIT; stall_req=1 from the next cycle.
  - FORCE: stall_req=1.
    - Pipeline WB holds pipe_we=0; the head pops.
    - On the first pop: stall_req=0, wcnt=0, → WAIT if still non-empty, else IDLE.
    - If pipe_we asserts anyway, pipe still wins and the FSM stays in FORCE.
- count width is clog2(FIFO_DEPTH)+1. Read/write pointers wrap modulo FIFO_DEPTH.

Test Plan:
- Reset, then pipe_we=1, rd=5, data=0xDEADBEEF → next cycle rf_RegWrite=1, rf_WriteReg=5, rf_WriteData=0xDEADBEEF. pipe_rd=0 → rf_RegWrite=0.
- Idle pipe, MDU handshake in cycle N with rd=7, data=0x12345678 → rf_RegWrite=1 with rd=7 in cycle N+2. pend_hit1=1 for chk_rs1=7 during N+1 only.
- pipe_we held high with rd=3, three MDU pushes → mdu_ready=0 after 2 pushes (FIFO_DEPTH=2). stall_req=1 after 4 blocked cycles. Drop pipe_we → 2 pops in order, stall_req deasserts after the first pop.
- Queue MDU rd=9 data=0xA, then pipe write rd=9 data=0xB before the pop → rf writes 0xB once. The squashed pop gives rf_RegWrite=0, so x9 ends as 0xB. pend_hit for 9 drops the cycle after the squash.
- With FIFO full, a simultaneous pop cycle and mdu_valid → no push that cycle (ready=0). Push accepted next cycle; pointers wrap correctly over 6 push/pop pairs with data order preserved.
- Assert reset_n=0 mid-operation with 2 entries queued and stall_req=1 → all outputs 0 immediately (async), mdu_ready=1, no stale write after release.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the single register-file write port between pipeline writeback (fixed priority)
// and a small FIFO of long-latency MDU results, with pending-write hit flags and an anti-starvation stall.
module regfile_wb_arbiter #(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned MAX_WAIT   = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pipe_we,
  input  logic [4:0]  pipe_rd,
  input  logic [31:0] pipe_wdata,
  input  logic        mdu_valid,
  input  logic [4:0]  mdu_rd,
  input  logic [31:0] mdu_wdata,
  output logic        mdu_ready,
  input  logic [4:0]  chk_rs1,
  input  logic [4:0]  chk_rs2,
  output logic        pend_hit1,
  output logic        pend_hit2,
  output logic        stall_req,
  output logic        rf_RegWrite,
  output logic [4:0]  rf_WriteReg,
  output logic [31:0] rf_WriteData
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned WW = $clog2(MAX_WAIT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_FORCE
  } state_t;

  logic [FIFO_DEPTH-1:0] r_live;
  logic [4:0]            r_rd   [FIFO_DEPTH];
  logic [31:0]           r_data [FIFO_DEPTH];
  logic [AW-1:0]         r_wptr;
  logic [AW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic [WW-1:0]         r_wcnt;
  state_t                r_state;
  logic                  r_stall;
  logic                  r_we;
  logic [4:0]            r_wreg;
  logic [31:0]           r_wdata;

  logic          w_pipe_eff;
  logic          w_hs;
  logic          w_push;
  logic          w_pop;
  logic [CW-1:0] w_count_nxt;
  logic          w_hit1;
  logic          w_hit2;

  assign w_pipe_eff  = pipe_we & (|pipe_rd);
  assign mdu_ready   = (r_count < CW'(FIFO_DEPTH));
  assign w_hs        = mdu_valid & mdu_ready;
  assign w_push      = w_hs & (|mdu_rd);
  assign w_pop       = ~w_pipe_eff & (r_count != '0);
  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);

  // Live bits are cleared on pop, so only occupied, unsquashed entries can hit.
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
      if (r_live[i] && (r_rd[i] == chk_rs1)) w_hit1 = 1'b1;
      if (r_live[i] && (r_rd[i] == chk_rs2)) w_hit2 = 1'b1;
    end
  end

  assign pend_hit1 = w_hit1 & (|chk_rs1);
  assign pend_hit2 = w_hit2 & (|chk_rs2);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_live  <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_rd[i]   <= '0;
        r_data[i] <= '0;
      end
    end else begin
      // A younger pipeline write to the same rd makes the queued value dead.
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        if (w_pipe_eff && r_live[i] && (r_rd[i] == pipe_rd)) r_live[i] <= 1'b0;
      end
      if (w_pop) begin
        r_live[r_rptr] <= 1'b0;
        r_rptr         <= r_rptr + AW'(1);
      end
      if (w_push) begin
        r_live[r_wptr] <= 1'b1;
        r_rd[r_wptr]   <= mdu_rd;
        r_data[r_wptr] <= mdu_wdata;
        r_wptr         <= r_wptr + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_wreg  <= '0;
      r_wdata <= '0;
    end else if (w_pipe_eff) begin
      r_we    <= 1'b1;
      r_wreg  <= pipe_rd;
      r_wdata <= pipe_wdata;
    end else if (w_pop) begin
      r_we    <= r_live[r_rptr];
      r_wreg  <= r_rd[r_rptr];
      r_wdata <= r_data[r_rptr];
    end else begin
      r_we    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_wcnt  <= '0;
      r_stall <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_wcnt  <= '0;
          r_stall <= 1'b0;
          if (w_count_nxt != '0) r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (w_count_nxt == '0) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
          end else if (w_pop) begin
            r_wcnt  <= '0;
          end else if ((int'(r_wcnt) + 1) >= int'(MAX_WAIT)) begin
            r_state <= S_FORCE;
            r_wcnt  <= WW'(MAX_WAIT);
            r_stall <= 1'b1;
          end else begin
            r_wcnt  <= r_wcnt + WW'(1);
          end
        end
        S_FORCE: begin
          if (w_pop) begin
            r_stall <= 1'b0;
            r_wcnt  <= '0;
            r_state <= (w_count_nxt != '0) ? S_WAIT : S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_wcnt  <= '0;
          r_stall <= 1'b0;
        end
      endcase
    end
  end

  assign stall_req    = r_stall;
  assign rf_RegWrite  = r_we;
  assign rf_WriteReg  = r_wreg;
  assign rf_WriteData = r_wdata;

endmodule
